// File: rtl/mem_arbiter_fsm.sv
// Registered FSM arbiter sharing one single-port RAM between fetch and data ports.
// Optional ARB_PERF_EN macro adds grant and busy-cycle performance counters.
module mem_arbiter_fsm #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              err,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_busy_cycles
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [3:0] d_streak;
    logic [7:0] to_cnt;

    logic d_elig;
    logic i_elig;
    logic grant_i;
    logic grant_d;

    // A requester still holding its request during its own done cycle is masked.
    always_comb begin
        d_elig  = (d_ren | d_wen) & ~d_done;
        i_elig  = i_req & ~i_done;
        grant_i = i_elig & ((d_streak == STREAK_MAX) | ~d_elig);
        grant_d = d_elig & ~grant_i;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            d_streak  <= '0;
            to_cnt    <= '0;
            i_rdata   <= '0;
            i_done    <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state     <= I_ACC;
                        ram_ren   <= 1'b1;
                        ram_wen   <= 1'b0;
                        ram_addr  <= i_addr;
                        ram_wdata <= '0;
                        d_streak  <= '0;
                    end else if (grant_d) begin
                        state    <= D_ACC;
                        // Read wins when both strobes are raised.
                        ram_ren   <= d_ren;
                        ram_wen   <= ~d_ren;
                        ram_addr  <= d_addr;
                        ram_wdata <= d_ren ? '0 : d_wdata;
                        if (!i_req) begin
                            d_streak <= '0;
                        end else if (d_streak != STREAK_MAX) begin
                            d_streak <= d_streak + 4'd1;
                        end
                    end
                end
                I_ACC, D_ACC: begin
                    if (!ram_busy || to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        to_cnt    <= '0;
                        ram_ren   <= 1'b0;
                        ram_wen   <= 1'b0;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                        err       <= ram_busy;
                        if (state == I_ACC) begin
                            i_done  <= 1'b1;
                            i_rdata <= ram_busy ? '0 : ram_rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= (ram_busy || ram_wen) ? '0 : ram_rdata;
                        end
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] i_grants;
    logic [31:0] d_grants;
    logic [31:0] busy_cycles;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            i_grants    <= '0;
            d_grants    <= '0;
            busy_cycles <= '0;
        end else begin
            if (state == IDLE && grant_i) begin
                i_grants <= i_grants + 32'd1;
            end
            if (state == IDLE && grant_d) begin
                d_grants <= d_grants + 32'd1;
            end
            if (state != IDLE && ram_busy) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
        end
    end

    assign perf_i_grants    = i_grants;
    assign perf_d_grants    = d_grants;
    assign perf_busy_cycles = busy_cycles;
`else
    assign perf_i_grants    = '0;
    assign perf_d_grants    = '0;
    assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed, table-driven bench for mem_arbiter_fsm plus hand-written corner sequences.
module tb_mem_arbiter_fsm;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_busy_cycles;

    int checks = 0;
    int errors = 0;

    mem_arbiter_fsm #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4),
        .TIMEOUT_CYC(8)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_done(i_done),
        .d_ren(d_ren),
        .d_wen(d_wen),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_done(d_done),
        .err(err),
        .ram_ren(ram_ren),
        .ram_wen(ram_wen),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_busy(ram_busy),
        .perf_i_grants(perf_i_grants),
        .perf_d_grants(perf_d_grants),
        .perf_busy_cycles(perf_busy_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        i_req, d_ren, d_wen, busy;
        logic [31:0] i_addr, d_addr, d_wdata, rdata;
        logic        e_ren, e_wen, e_idone, e_ddone, e_err;
        logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ram_busy = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0;
    endtask

    function automatic vec_t mk(input logic ir, dr, dw, bz, input logic [31:0] ia, da, dwd, rd,
                                input logic er, ew, eid, edd, eer,
                                input logic [31:0] ea, ewd, eir, edr);
        vec_t v;
        v.i_req = ir; v.d_ren = dr; v.d_wen = dw; v.busy = bz;
        v.i_addr = ia; v.d_addr = da; v.d_wdata = dwd; v.rdata = rd;
        v.e_ren = er; v.e_wen = ew; v.e_idone = eid; v.e_ddone = edd; v.e_err = eer;
        v.e_addr = ea; v.e_wdata = ewd; v.e_irdata = eir; v.e_drdata = edr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fetch, store with two busy cycles, simultaneous request, read+write collapse.
        vecs[0]  = mk(1,0,0,0, 32'h100,0,0,32'hDEADBEEF, 1,0,0,0,0, 32'h100,0,0,0);
        vecs[1]  = mk(1,0,0,0, 32'h100,0,0,32'hDEADBEEF, 0,0,1,0,0, 0,0,32'hDEADBEEF,0);
        vecs[2]  = mk(1,0,0,0, 32'h100,0,0,32'hDEADBEEF, 0,0,0,0,0, 0,0,32'hDEADBEEF,0);
        vecs[3]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,32'hDEADBEEF,0);
        vecs[4]  = mk(0,0,1,0, 0,32'h40,32'h12345678,32'hAAAA5555,
                      0,1,0,0,0, 32'h40,32'h12345678,32'hDEADBEEF,0);
        vecs[5]  = mk(0,0,1,1, 0,32'h40,32'h12345678,32'hAAAA5555,
                      0,1,0,0,0, 32'h40,32'h12345678,32'hDEADBEEF,0);
        vecs[6]  = mk(0,0,1,1, 0,32'h40,32'h12345678,32'hAAAA5555,
                      0,1,0,0,0, 32'h40,32'h12345678,32'hDEADBEEF,0);
        vecs[7]  = mk(0,0,1,0, 0,32'h40,32'h12345678,32'hAAAA5555,
                      0,0,0,1,0, 0,0,32'hDEADBEEF,0);
        vecs[8]  = mk(0,0,1,0, 0,32'h40,32'h12345678,32'hAAAA5555,
                      0,0,0,0,0, 0,0,32'hDEADBEEF,0);
        vecs[9]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,32'hDEADBEEF,0);
        vecs[10] = mk(1,1,0,0, 32'h200,32'h80,0,32'h11111111,
                      1,0,0,0,0, 32'h80,0,32'hDEADBEEF,0);
        vecs[11] = mk(1,1,0,0, 32'h200,32'h80,0,32'h11111111,
                      0,0,0,1,0, 0,0,32'hDEADBEEF,32'h11111111);
        vecs[12] = mk(1,1,0,0, 32'h200,32'h80,0,32'h22222222,
                      1,0,0,0,0, 32'h200,0,32'hDEADBEEF,32'h11111111);
        vecs[13] = mk(1,0,0,0, 32'h200,32'h80,0,32'h22222222,
                      0,0,1,0,0, 0,0,32'h22222222,32'h11111111);
        vecs[14] = mk(1,0,0,0, 32'h200,32'h80,0,32'h22222222,
                      0,0,0,0,0, 0,0,32'h22222222,32'h11111111);
        vecs[15] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,32'h22222222,32'h11111111);
        vecs[16] = mk(0,1,1,0, 0,32'h44,32'hFFFF0000,32'h33333333,
                      1,0,0,0,0, 32'h44,0,32'h22222222,32'h11111111);
        vecs[17] = mk(0,1,1,0, 0,32'h44,32'hFFFF0000,32'h33333333,
                      0,0,0,1,0, 0,0,32'h22222222,32'h33333333);
        vecs[18] = mk(0,1,1,0, 0,32'h44,32'hFFFF0000,32'h33333333,
                      0,0,0,0,0, 0,0,32'h22222222,32'h33333333);
        vecs[19] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,32'h22222222,32'h33333333);

        quiet();
        nRST = 1'b0;
        #12;
        check("reset_ctrl", 128'({ram_ren, ram_wen, i_done, d_done, err}), 128'(0));
        check("reset_bus", {ram_addr, ram_wdata, i_rdata, d_rdata}, 128'(0));
        check("reset_perf", 128'({perf_i_grants, perf_d_grants, perf_busy_cycles}), 128'(0));
        nRST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            i_req = vecs[i].i_req; d_ren = vecs[i].d_ren; d_wen = vecs[i].d_wen;
            ram_busy = vecs[i].busy; i_addr = vecs[i].i_addr; d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; ram_rdata = vecs[i].rdata;
            tick();
            check($sformatf("vec%0d_ctrl", i), 128'({ram_ren, ram_wen, i_done, d_done, err}),
                  128'({vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_idone, vecs[i].e_ddone,
                        vecs[i].e_err}));
            check($sformatf("vec%0d_ram", i), 128'({ram_addr, ram_wdata}),
                  128'({vecs[i].e_addr, vecs[i].e_wdata}));
            check($sformatf("vec%0d_rdata", i), 128'({i_rdata, d_rdata}),
                  128'({vecs[i].e_irdata, vecs[i].e_drdata}));
        end

        // Starvation bound: i_req is raised on each data grant cycle only, so the
        // streak climbs to the limit and the fifth contested grant must go to fetch.
        quiet();
        i_addr = 32'h300; d_addr = 32'h500; ram_rdata = 32'h5A5A5A5A;
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1; d_ren = 1'b1;
            tick();
            check($sformatf("starve_d_grant%0d", k), 128'({ram_ren, ram_addr}),
                  128'({1'b1, 32'h500}));
            i_req = 1'b0;
            tick();
            check($sformatf("starve_d_done%0d", k), 128'(d_done), 128'(1));
            tick();
        end
        i_req = 1'b1; d_ren = 1'b1;
        tick();
        check("starve_i_grant", 128'({ram_ren, ram_addr}), 128'({1'b1, 32'h300}));
        i_req = 1'b0;
        tick();
        check("starve_i_done", 128'({i_done, d_done}), 128'({1'b1, 1'b0}));
        tick();
        check("starve_d_after_i", 128'({ram_ren, ram_addr}), 128'({1'b1, 32'h500}));
        tick();
        d_ren = 1'b0;
        tick();
        // Streak must be back at zero: a contested grant goes to data again.
        i_req = 1'b1; d_ren = 1'b1;
        tick();
        check("starve_streak_clear", 128'({ram_ren, ram_addr}), 128'({1'b1, 32'h500}));
        i_req = 1'b0;
        tick();
        d_ren = 1'b0;
        tick();

        // Busy-timeout abort after eight stuck access cycles.
        quiet();
        d_ren = 1'b1; d_addr = 32'h60; ram_busy = 1'b1; ram_rdata = 32'h99999999;
        tick();
        check("to_grant", 128'({ram_ren, ram_addr}), 128'({1'b1, 32'h60}));
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("to_wait%0d", c), 128'({ram_ren, d_done, err}),
                  128'({1'b1, 1'b0, 1'b0}));
        end
        tick();
        check("to_abort", 128'({ram_ren, i_done, d_done, err}), 128'({1'b0, 1'b0, 1'b1, 1'b1}));
        check("to_rdata", 128'(d_rdata), 128'(0));
        quiet();
        tick();
        check("to_idle", 128'({ram_ren, ram_wen, d_done, err}), 128'(0));

        // Reset in the middle of a store.
        d_wen = 1'b1; d_addr = 32'h70; d_wdata = 32'hCAFE; ram_busy = 1'b1;
        tick();
        check("rst_access", 128'({ram_wen, ram_addr}), 128'({1'b1, 32'h70}));
        #3 nRST = 1'b0;
        #1;
        check("rst_async_drop", 128'({ram_ren, ram_wen}), 128'(0));
        tick();
        check("rst_no_done", 128'({d_done, err, ram_wen}), 128'(0));
        #3 nRST = 1'b1;
        quiet();
        check("rst_perf_clear", 128'({perf_i_grants, perf_d_grants, perf_busy_cycles}),
              128'(0));
        i_req = 1'b1; i_addr = 32'h120; ram_rdata = 32'h0BADF00D;
        tick();
        check("rst_fetch_grant", 128'({ram_ren, ram_addr}), 128'({1'b1, 32'h120}));
        tick();
        check("rst_fetch_done", 128'({i_done, d_done, err, i_rdata}),
              128'({1'b1, 1'b0, 1'b0, 32'h0BADF00D}));
`ifdef ARB_PERF_EN
        check("perf_counts", 128'({perf_i_grants, perf_d_grants, perf_busy_cycles}),
              128'({32'd1, 32'd0, 32'd0}));
`else
        check("perf_tied", 128'({perf_i_grants, perf_d_grants, perf_busy_cycles}), 128'(0));
`endif
        quiet();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_fsm.md
Name: mem_arbiter_fsm

Overview:
Registered, FSM-based arbiter that shares one single-port RAM between the instruction-fetch port and the data (load/store) port.
- Latches each granted request and drives the RAM from those registers.
- Waits out ram_busy, then returns the result with a one-cycle done pulse.
- Data has priority, with a starvation bound that guarantees fetch progress.
- A busy-timeout guard prevents the core from hanging on an unresponsive RAM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, max consecutive data grants while i_req is pending (1..15)
TIMEOUT_CYC, 64, access-state cycles with ram_busy high before abort (2..255)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request; held until i_done
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data; valid while i_done=1
i_done  out  1  fetch complete, one-cycle pulse
d_ren  in  1  data read request; held until d_done
d_wen  in  1  data write request; held until d_done
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid while d_done=1
d_done  out  1  data complete, one-cycle pulse
err  out  1  timeout abort; pulses with the matching done
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM store data
ram_rdata  in  DATA_W  RAM load data
ram_busy  in  1  RAM not ready

Behaviour:
Reset (asynchronous)
- State goes to IDLE.
- All outputs go to 0.
- Latched address/data/op registers, streak counter and timeout counter clear.
- Reset mid-access drops ram_ren/ram_wen immediately. No done is issued for the killed access.

FSM states: IDLE, I_ACC, D_ACC.

IDLE
- ram_ren=0, ram_wen=0, ram_addr=0, ram_wdata=0.
- Eligible requests: d_ren|d_wen unless d_done=1 this cycle; i_req unless i_done=1 this cycle. This masks the request a requester is still dropping.
- Grant choice: if i_req is eligible and d_streak==STARVE_MAX, grant I. Otherwise data wins if eligible, else I if eligible.
- On a grant: latch addr (plus wdata and op for data) and go to I_ACC or D_ACC at the next edge.

d_streak
- Increments on a D grant while i_req is high; saturates at STARVE_MAX.
- Clears on an I grant, or on a D grant with i_req low.

d_ren and d_wen both high
- Treated as a read; the write is ignored.

I_ACC / D_ACC
- RAM is driven only from the latched registers. Input changes mid-access are ignored.
- ram_ren=1 for reads/fetch; ram_wen=1 for writes.
- ram_busy low: capture ram_rdata into the rdata output register (writes capture 0). Pulse the matching done on the next cycle, which is also the IDLE cycle.
- ram_busy high: the timeout counter increments. When it reaches TIMEOUT_CYC, go to IDLE and pulse done plus err with rdata=0.

Latency and outputs
- Minimum latency, request to done: 3 cycles (grant edge, access cycle, done cycle).
- rdata outputs hold their value between pulses.
- done and err are never asserted for both ports in the same cycle.

Optional Feature:
Macro ARB_PERF_EN. When defined, adds outputs perf_i_grants[31:0], perf_d_grants[31:0] and perf_busy_cycles[31:0]:
- perf_i_grants / perf_d_grants count grants per port.
- perf_busy_cycles counts access-state cycles with ram_busy=1.
- All three wrap at 2^32 and clear on reset.

When not defined, those ports are still present and tied to 0, with no counter logic.

Test Plan:
- Fetch, no contention: i_req=1, i_addr=0x100, ram_busy=0, ram_rdata=0xDEADBEEF -> ram_ren=1 with ram_addr=0x100 one cycle after request; i_done=1 and i_rdata=0xDEADBEEF on the third cycle.
- Store with 2 busy cycles: d_wen=1, d_addr=0x40, d_wdata=0x12345678, ram_busy high for 2 access cycles -> ram_wen=1 held for 3 cycles with stable addr/data; d_done on cycle 5; d_rdata=0.
- Starvation bound: d_ren held continuously (re-asserted after each d_done) while i_req=1, STARVE_MAX=4 -> exactly 4 D grants, then an I grant; d_streak returns to 0.
- Simultaneous request: d_ren=1 and i_req=1 in the same IDLE cycle, streak 0 -> D granted first, I granted immediately after d_done.
- Timeout: ram_busy stuck high, TIMEOUT_CYC=8 -> abort after 8 access cycles; d_done=1, err=1, d_rdata=0; FSM back in IDLE.
- Reset mid-access: nRST low during D_ACC -> ram_ren/ram_wen=0 asynchronously, no d_done; after release, a new i_req completes normally. With ARB_PERF_EN defined, perf counters read 0 after reset.
